// File: rtl/mem_access_unit_if.sv
// Request, load-return and data-memory signals of the MEM-stage access unit.
// master: the access unit itself; slave: pipeline plus data memory.
interface mem_access_unit_if;
    logic        ReqValid;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWD;
    logic        Stall;
    logic        LoadValid;
    logic [31:0] LoadData;
    logic        AddrErr;
    logic [31:0] MemA;
    logic [31:0] MemWD;
    logic        MemWE;
    logic [31:0] MemRD;

    modport master (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWD, MemRD,
        output Stall, LoadValid, LoadData, AddrErr, MemA, MemWD, MemWE
    );

    modport slave (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWD, MemRD,
        input  Stall, LoadValid, LoadData, AddrErr, MemA, MemWD, MemWE
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-wide data memory.
// Sub-word stores are done as read-modify-write so memory never needs byte enables.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (AddrErr pulse, no memory access); otherwise low address bits are ignored.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no request in flight, Stall low, ready to accept
// READ      | load: MemA driven, MemRD captured at the end of the cycle
// RMW_READ  | sub-word store: old word read, merged at end of cycle
// RMW_WRITE | sub-word store: merged word written (MemWE high)
// WRITE     | word store: ReqWD written (MemWE high)
module mem_access_unit (
    input  logic             CLK,
    input  logic             RST_N,
    mem_access_unit_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, RMW_READ, RMW_WRITE, WRITE} state_t;

    state_t      state, state_next;
    logic [1:0]  addr_lo;
    logic [1:0]  size;
    logic        sign_ext;
    logic [15:0] wd_low;
    logic [29:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        load_valid;
    logic [31:0] load_data;
    logic        addr_err;
    logic        accept;
    logic        misalign;

    assign accept = (state == IDLE) && bus.ReqValid;

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((bus.ReqSize == 2'b01) && bus.ReqAddr[0]) ||
                      (bus.ReqSize[1] && (bus.ReqAddr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Right-justify the addressed lane and extend it; word loads pass through.
    function automatic logic [31:0] extract(logic [31:0] rd, logic [1:0] sz,
                                            logic [1:0] lo, logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        if (sz == 2'b00)
            extract = {{24{sgn & b[7]}}, b};
        else if (sz == 2'b01)
            extract = {{16{sgn & h[15]}}, h};
        else
            extract = rd;
    endfunction

    // Replace the target byte/half lane of the old word with the store data.
    function automatic logic [31:0] merge(logic [31:0] old, logic [15:0] d,
                                          logic [1:0] sz, logic [1:0] lo);
        merge = old;
        if (sz == 2'b00) begin
            case (lo)
                2'd0:    merge[7:0]   = d[7:0];
                2'd1:    merge[15:8]  = d[7:0];
                2'd2:    merge[23:16] = d[7:0];
                default: merge[31:24] = d[7:0];
            endcase
        end else if (lo[1]) begin
            merge[31:16] = d;
        end else begin
            merge[15:0] = d;
        end
    endfunction

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; a trapped misaligned request never leaves IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !misalign) begin
                    if (!bus.ReqWrite)     state_next = READ;
                    else if (bus.ReqSize[1]) state_next = WRITE;
                    else                   state_next = RMW_READ;
                end
            end
            READ:      state_next = IDLE;
            RMW_READ:  state_next = RMW_WRITE;
            RMW_WRITE: state_next = IDLE;
            WRITE:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Request capture, memory-side registers and load return.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            addr_lo    <= 2'b00;
            size       <= 2'b00;
            sign_ext   <= 1'b0;
            wd_low     <= 16'h0;
            mem_addr   <= 30'h0;
            mem_wd     <= 32'h0;
            mem_we     <= 1'b0;
            load_valid <= 1'b0;
            load_data  <= 32'h0;
            addr_err   <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            load_valid <= 1'b0;
            addr_err   <= 1'b0;
            if (accept) begin
                addr_lo  <= bus.ReqAddr[1:0];
                size     <= bus.ReqSize;
                sign_ext <= bus.ReqSigned;
                wd_low   <= bus.ReqWD[15:0];
                addr_err <= misalign;
                if (!misalign) begin
                    mem_addr <= bus.ReqAddr[31:2];
                    if (bus.ReqWrite && bus.ReqSize[1]) begin
                        mem_wd <= bus.ReqWD;
                        mem_we <= 1'b1;
                    end
                end
            end
            case (state)
                READ: begin
                    load_data  <= extract(bus.MemRD, size, addr_lo, sign_ext);
                    load_valid <= 1'b1;
                end
                RMW_READ: begin
                    mem_wd <= merge(bus.MemRD, wd_low, size, addr_lo);
                    mem_we <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Stall     = (state != IDLE);
    assign bus.MemA      = {mem_addr, 2'b00};
    assign bus.MemWD     = mem_wd;
    assign bus.MemWE     = mem_we;
    assign bus.LoadValid = load_valid;
    assign bus.LoadData  = load_data;
    assign bus.AddrErr   = addr_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 16-word memory at 0x10010000, directed cases and
// random requests checked against a byte-level reference model.
module tb_mem_access_unit;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    mem_access_unit_if bus();
    mem_access_unit dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    logic [31:0] mem     [0:15];
    logic [31:0] seed    [0:15];
    logic [31:0] ref_mem [0:15];
    logic        do_init = 1'b0;
    logic [31:0] last_load = 32'h0;
    int n_assert = 0;
    int n_fail   = 0;

    assign bus.MemRD = mem[bus.MemA[5:2]];

    // Memory: loaded from seed while do_init, otherwise written by the DUT.
    always @(posedge CLK) begin
        if (do_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= seed[i];
        end else if (bus.MemWE) begin
            mem[bus.MemA[5:2]] <= bus.MemWD;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Effective byte offset of the access within its word.
    function automatic int offset(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return int'(a[1:0]);
        if (sz == 2'b01) return a[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic logic model_misalign(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (nbytes(sz) == 2 && (a % 2) != 0) || (nbytes(sz) == 4 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sg, input logic [31:0] a);
        int n = nbytes(sz);
        logic [31:0] v = w >> (8 * offset(sz, a));
        logic [31:0] mask;
        if (n == 4) return v;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = v & mask;
        if (sg && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] d);
        logic [7:0] bytes [4];
        int off = offset(sz, a);
        for (int i = 0; i < 4; i++) bytes[i] = old[8 * i +: 8];
        for (int i = 0; i < nbytes(sz); i++) bytes[off + i] = d[8 * i +: 8];
        return {bytes[3], bytes[2], bytes[1], bytes[0]};
    endfunction

    // Issue one request and watch the three cycles after acceptance.
    task automatic run_req(input string tag, input logic w, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] d);
        logic        mis = model_misalign(sz, a);
        int          idx = int'(a[5:2]);
        int          stall_n = 0, we_n = 0, lv_n = 0, ae_n = 0;
        int          we_k = 0, lv_k = 0, ae_k = 0;
        logic [31:0] we_a = 0, we_d = 0, lv_d = 0, a1 = 0;
        logic [31:0] exp_word;
        @(negedge CLK);
        check({tag, ".stall_pre"}, {31'h0, bus.Stall}, 32'h0);
        bus.ReqValid = 1'b1; bus.ReqWrite = w; bus.ReqSize = sz;
        bus.ReqSigned = sg; bus.ReqAddr = a; bus.ReqWD = d;
        @(posedge CLK); #1;
        bus.ReqValid = 1'b0;
        bus.ReqWD = $urandom;
        for (int k = 1; k <= 3; k++) begin
            if (k == 1) a1 = bus.MemA;
            if (bus.Stall) stall_n++;
            if (bus.MemWE) begin we_n++; we_k = k; we_a = bus.MemA; we_d = bus.MemWD; end
            if (bus.LoadValid) begin lv_n++; lv_k = k; lv_d = bus.LoadData; end
            if (bus.AddrErr) begin ae_n++; ae_k = k; end
            if (k < 3) begin @(posedge CLK); #1; end
        end
        if (mis) begin
            check({tag, ".ae_k"}, ae_k, 1);
            check({tag, ".ae_n"}, ae_n, 1);
            check({tag, ".stall"}, stall_n, 0);
            check({tag, ".we_n"}, we_n, 0);
            check({tag, ".lv_n"}, lv_n, 0);
        end else begin
            check({tag, ".ae_n"}, ae_n, 0);
            check({tag, ".mema"}, a1, {a[31:2], 2'b00});
            if (!w) begin
                check({tag, ".stall"}, stall_n, 1);
                check({tag, ".we_n"}, we_n, 0);
                check({tag, ".lv_k"}, lv_k, 2);
                check({tag, ".lv_n"}, lv_n, 1);
                last_load = model_load(ref_mem[idx], sz, sg, a);
                check({tag, ".ldata"}, lv_d, last_load);
            end else begin
                exp_word = model_store(ref_mem[idx], sz, a, d);
                check({tag, ".stall"}, stall_n, (nbytes(sz) == 4) ? 1 : 2);
                check({tag, ".we_n"}, we_n, 1);
                check({tag, ".we_k"}, we_k, (nbytes(sz) == 4) ? 1 : 2);
                check({tag, ".we_a"}, we_a, {a[31:2], 2'b00});
                check({tag, ".we_d"}, we_d, exp_word);
                check({tag, ".lv_n"}, lv_n, 0);
                ref_mem[idx] = exp_word;
            end
        end
        check({tag, ".lhold"}, bus.LoadData, last_load);
        check({tag, ".mem"}, mem[idx], ref_mem[idx]);
    endtask

    initial begin
        bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'b10;
        bus.ReqSigned = 1'b0; bus.ReqAddr = 32'h0; bus.ReqWD = 32'h0;
        for (int i = 0; i < 16; i++) begin
            seed[i] = $urandom;
            ref_mem[i] = seed[i];
        end
        do_init = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        do_init = 1'b0;
        check("rst.stall", {31'h0, bus.Stall}, 32'h0);
        check("rst.mema", bus.MemA, 32'h0);
        check("rst.memwd", bus.MemWD, 32'h0);
        check("rst.memwe", {31'h0, bus.MemWE}, 32'h0);
        check("rst.lv", {31'h0, bus.LoadValid}, 32'h0);
        check("rst.ldata", bus.LoadData, 32'h0);
        check("rst.ae", {31'h0, bus.AddrErr}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        run_req("sw_dead", 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
        run_req("lw_dead", 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0);
        run_req("sw_base", 1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h1122_3344);
        run_req("sb_aa",   1'b1, 2'b00, 1'b0, 32'h1001_0002, 32'h0000_00AA);
        check("sb_aa.word", ref_mem[0], 32'h11AA_3344);
        run_req("lb_s",    1'b0, 2'b00, 1'b1, 32'h1001_0002, 32'h0);
        check("lb_s.val", last_load, 32'hFFFF_FFAA);
        run_req("lbu",     1'b0, 2'b00, 1'b0, 32'h1001_0002, 32'h0);
        run_req("lh_s2",   1'b0, 2'b01, 1'b1, 32'h1001_0002, 32'h0);
        check("lh_s2.val", last_load, 32'h0000_11AA);
        run_req("sw_base2", 1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h1122_3344);
        run_req("sh_8001", 1'b1, 2'b01, 1'b0, 32'h1001_0000, 32'h0000_8001);
        check("sh_8001.word", ref_mem[0], 32'h1122_8001);
        run_req("lh_s0",   1'b0, 2'b01, 1'b1, 32'h1001_0000, 32'h0);
        check("lh_s0.val", last_load, 32'hFFFF_8001);
        run_req("lw_mis",  1'b0, 2'b10, 1'b0, 32'h1001_0001, 32'h0);
        run_req("sz11",    1'b1, 2'b11, 1'b0, 32'h1001_0008, 32'h0BAD_F00D);

        // Reset while the sub-word store sits in RMW_READ.
        @(negedge CLK);
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqSize = 2'b00;
        bus.ReqSigned = 1'b0; bus.ReqAddr = 32'h1001_0001; bus.ReqWD = 32'h55;
        @(posedge CLK); #1;
        bus.ReqValid = 1'b0;
        check("rmwrst.stall", {31'h0, bus.Stall}, 32'h1);
        check("rmwrst.we1", {31'h0, bus.MemWE}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        check("rmwrst.stall0", {31'h0, bus.Stall}, 32'h0);
        check("rmwrst.we2", {31'h0, bus.MemWE}, 32'h0);
        check("rmwrst.mema", bus.MemA, 32'h0);
        check("rmwrst.memwd", bus.MemWD, 32'h0);
        check("rmwrst.lv", {31'h0, bus.LoadValid}, 32'h0);
        check("rmwrst.ldata", bus.LoadData, 32'h0);
        check("rmwrst.ae", {31'h0, bus.AddrErr}, 32'h0);
        last_load = 32'h0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check("rmwrst.we3", {31'h0, bus.MemWE}, 32'h0);
        check("rmwrst.mem", mem[0], ref_mem[0]);

        for (int i = 0; i < 40; i++) begin
            run_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 32'h1001_0000 + 32'($urandom_range(0, 63)),
                    $urandom);
        end
        for (int i = 0; i < 16; i++) check("final.mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
